// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control codes and the ID/EX latch layout.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_AND    = 4'd0,
    ALU_OR     = 4'd1,
    ALU_ADD    = 4'd2,
    ALU_SUB    = 4'd3,
    ALU_SLT    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SLLV   = 4'd6,
    ALU_XOR    = 4'd7,
    ALU_NOR    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_SRL    = 4'd10,
    ALU_SRLV   = 4'd11,
    ALU_SRA    = 4'd12,
    ALU_SRAV   = 4'd13,
    ALU_PASS_A = 4'd14,
    ALU_PASS_B = 4'd15
  } alu_ctrl_e;

  // A bubble decodes as a harmless ADD so downstream never sees an undefined op.
  localparam alu_ctrl_e BUBBLE_CTRL = ALU_ADD;
  localparam alu_ctrl_e RESET_CTRL  = ALU_AND;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    alu_ctrl_e   alu_ctrl;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic        src_a_imm;
    logic        src_b_imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
  } id_ex_t;

  function automatic id_ex_t empty_stage(input alu_ctrl_e ctrl);
    id_ex_t s;
    s          = '0;
    s.alu_ctrl = ctrl;
    return s;
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand selector for one ALU input: immediate, forwarded result or latched register data.
// Forwarding paths exist only when FORWARDING_EN is defined.
module fwd_mux (
  input  logic [4:0]  reg_addr,
  input  logic [31:0] reg_data,
  input  logic [31:0] imm,
  input  logic        sel_imm,
  input  logic        exmem_wr,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_res,
  input  logic        memwb_wr,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_res,
  output logic [31:0] operand,
  output logic [31:0] fwd_data
);

`ifdef FORWARDING_EN
  // Register 0 is hard-wired, so a producer targeting it must never be forwarded.
  always_comb begin
    fwd_data = reg_data;
    if (reg_addr != '0) begin
      if (exmem_wr && (exmem_rd == reg_addr)) begin
        fwd_data = exmem_res;
      end else if (memwb_wr && (memwb_rd == reg_addr)) begin
        fwd_data = memwb_res;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{reg_addr, exmem_wr, exmem_rd, exmem_res,
                        memwb_wr, memwb_rd, memwb_res};
  always_comb begin
    fwd_data = reg_data;
  end
`endif

  assign operand = sel_imm ? imm : fwd_data;

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand selection for the ALU (stall, flush, bubble).
// Optional EX/MEM and MEM/WB forwarding is enabled by defining FORWARDING_EN.
module id_ex_operand_stage
  import mips_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic        i_reg_write,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic [31:0] i_imm,
  input  logic [4:0]  i_rs_addr,
  input  logic [4:0]  i_rt_addr,
  input  logic [4:0]  i_rd_addr,
  input  logic [3:0]  i_alu_ctrl,
  input  logic        i_src_b_imm,
  input  logic        i_src_a_imm,
  input  logic        i_exmem_wr,
  input  logic        i_memwb_wr,
  input  logic [4:0]  i_exmem_rd,
  input  logic [4:0]  i_memwb_rd,
  input  logic [31:0] i_exmem_res,
  input  logic [31:0] i_memwb_res,
  output logic [31:0] o_op_a,
  output logic [31:0] o_op_b,
  output logic [31:0] o_store_data,
  output logic [3:0]  o_alu_ctrl,
  output logic [4:0]  o_rd_addr,
  output logic        o_reg_write,
  output logic        o_valid
);

  id_ex_t stage_q;
  id_ex_t stage_d;

  // Flush takes priority over stall so a squashed instruction cannot be held.
  always_comb begin
    stage_d = stage_q;
    if (i_flush) begin
      stage_d = empty_stage(BUBBLE_CTRL);
    end else if (!i_stall) begin
      stage_d.valid     = i_valid;
      stage_d.reg_write = i_reg_write;
      stage_d.alu_ctrl  = alu_ctrl_e'(i_alu_ctrl);
      stage_d.rs_addr   = i_rs_addr;
      stage_d.rt_addr   = i_rt_addr;
      stage_d.rd_addr   = i_rd_addr;
      stage_d.src_a_imm = i_src_a_imm;
      stage_d.src_b_imm = i_src_b_imm;
      stage_d.rs_data   = i_rs_data;
      stage_d.rt_data   = i_rt_data;
      stage_d.imm       = i_imm;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q <= empty_stage(RESET_CTRL);
    end else begin
      stage_q <= stage_d;
    end
  end

  logic [31:0] fwd_b;
  logic [31:0] unused_fwd_a;

  fwd_mux u_fwd_a (
    .reg_addr  (stage_q.rs_addr),
    .reg_data  (stage_q.rs_data),
    .imm       (stage_q.imm),
    .sel_imm   (stage_q.src_a_imm),
    .exmem_wr  (i_exmem_wr),
    .exmem_rd  (i_exmem_rd),
    .exmem_res (i_exmem_res),
    .memwb_wr  (i_memwb_wr),
    .memwb_rd  (i_memwb_rd),
    .memwb_res (i_memwb_res),
    .operand   (o_op_a),
    .fwd_data  (unused_fwd_a)
  );

  fwd_mux u_fwd_b (
    .reg_addr  (stage_q.rt_addr),
    .reg_data  (stage_q.rt_data),
    .imm       (stage_q.imm),
    .sel_imm   (stage_q.src_b_imm),
    .exmem_wr  (i_exmem_wr),
    .exmem_rd  (i_exmem_rd),
    .exmem_res (i_exmem_res),
    .memwb_wr  (i_memwb_wr),
    .memwb_rd  (i_memwb_rd),
    .memwb_res (i_memwb_res),
    .operand   (o_op_b),
    .fwd_data  (fwd_b)
  );

  assign o_store_data = fwd_b;
  assign o_alu_ctrl   = stage_q.alu_ctrl;
  assign o_rd_addr    = stage_q.rd_addr;
  assign o_valid      = stage_q.valid;
  assign o_reg_write  = stage_q.valid & stage_q.reg_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus randomized
// traffic against a behavioural model (follows FORWARDING_EN like the design).
module tb_id_ex_operand_stage;

  logic        i_clk, i_rst_n, i_stall, i_flush, i_valid, i_reg_write;
  logic [31:0] i_rs_data, i_rt_data, i_imm;
  logic [4:0]  i_rs_addr, i_rt_addr, i_rd_addr;
  logic [3:0]  i_alu_ctrl;
  logic        i_src_b_imm, i_src_a_imm;
  logic        i_exmem_wr, i_memwb_wr;
  logic [4:0]  i_exmem_rd, i_memwb_rd;
  logic [31:0] i_exmem_res, i_memwb_res;
  logic [31:0] o_op_a, o_op_b, o_store_data;
  logic [3:0]  o_alu_ctrl;
  logic [4:0]  o_rd_addr;
  logic        o_reg_write, o_valid;

  id_ex_operand_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid(i_valid), .i_reg_write(i_reg_write),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
    .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr), .i_rd_addr(i_rd_addr),
    .i_alu_ctrl(i_alu_ctrl), .i_src_b_imm(i_src_b_imm), .i_src_a_imm(i_src_a_imm),
    .i_exmem_wr(i_exmem_wr), .i_memwb_wr(i_memwb_wr),
    .i_exmem_rd(i_exmem_rd), .i_memwb_rd(i_memwb_rd),
    .i_exmem_res(i_exmem_res), .i_memwb_res(i_memwb_res),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_store_data(o_store_data),
    .o_alu_ctrl(o_alu_ctrl), .o_rd_addr(o_rd_addr),
    .o_reg_write(o_reg_write), .o_valid(o_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the instruction the stage currently holds.
  logic        m_valid, m_rw, m_sa, m_sb;
  logic [3:0]  m_ctrl;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_rsd, m_rtd, m_imm;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] d);
`ifdef FORWARDING_EN
    if (a != 0 && i_exmem_wr && i_exmem_rd == a) return i_exmem_res;
    if (a != 0 && i_memwb_wr && i_memwb_rd == a) return i_memwb_res;
`endif
    return d;
  endfunction

  task automatic model_clear(input logic [3:0] ctrl);
    {m_valid, m_rw, m_sa, m_sb} = '0;
    m_ctrl = ctrl;
    {m_rs, m_rt, m_rd} = '0;
    {m_rsd, m_rtd, m_imm} = '0;
  endtask

  task automatic model_edge();
    if (!i_rst_n)      model_clear(4'd0);
    else if (i_flush)  model_clear(4'd2);
    else if (!i_stall) begin
      m_valid = i_valid;   m_rw = i_reg_write; m_ctrl = i_alu_ctrl;
      m_rs = i_rs_addr;    m_rt = i_rt_addr;   m_rd = i_rd_addr;
      m_rsd = i_rs_data;   m_rtd = i_rt_data;  m_imm = i_imm;
      m_sa = i_src_a_imm;  m_sb = i_src_b_imm;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_op_a"}, o_op_a, m_sa ? m_imm : ref_fwd(m_rs, m_rsd));
    check({tag, "_op_b"}, o_op_b, m_sb ? m_imm : ref_fwd(m_rt, m_rtd));
    check({tag, "_store"}, o_store_data, ref_fwd(m_rt, m_rtd));
    check({tag, "_ctrl"}, {28'd0, o_alu_ctrl}, {28'd0, m_ctrl});
    check({tag, "_rd"}, {27'd0, o_rd_addr}, {27'd0, m_rd});
    check({tag, "_rw"}, {31'd0, o_reg_write}, {31'd0, m_valid & m_rw});
    check({tag, "_valid"}, {31'd0, o_valid}, {31'd0, m_valid});
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #2;
  endtask

  task automatic set_dec(input logic v, input logic rw, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] imm, input logic [3:0] ctrl, input logic sa,
                         input logic sb);
    i_valid = v; i_reg_write = rw; i_rs_addr = rs; i_rt_addr = rt; i_rd_addr = rd;
    i_rs_data = rsd; i_rt_data = rtd; i_imm = imm; i_alu_ctrl = ctrl;
    i_src_a_imm = sa; i_src_b_imm = sb;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                         input logic mw, input logic [4:0] mr, input logic [31:0] md);
    i_exmem_wr = ew; i_exmem_rd = er; i_exmem_res = ed;
    i_memwb_wr = mw; i_memwb_rd = mr; i_memwb_res = md;
  endtask

  task automatic randomize_dec();
    set_dec(1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom));
  endtask

  task automatic randomize_fwd();
    set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom), 5'($urandom_range(0, 7)), $urandom);
  endtask

  logic [31:0] exp_a;

  initial begin
    // Reset with busy inputs: outputs clear without any clock edge.
    i_rst_n = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    set_dec(1'b1, 1'b1, 5'd3, 5'd4, 5'd9, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678,
            4'd7, 1'b1, 1'b1);
    set_fwd(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222);
    model_clear(4'd0);
    #3;
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_rw", {31'd0, o_reg_write}, 32'd0);
    check("reset_ctrl", {28'd0, o_alu_ctrl}, 32'd0);
    check("reset_op_a", o_op_a, 32'd0);
    check("reset_op_b", o_op_b, 32'd0);
    check("reset_store", o_store_data, 32'd0);
    #9 i_rst_n = 1'b1;
    set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // Basic capture, one-cycle latency.
    set_dec(1'b1, 1'b1, 5'd3, 5'd4, 5'd8, 32'h10, 32'h20, 32'h0, 4'd2, 1'b0, 1'b0);
    tick();
    check("cap_op_a", o_op_a, 32'h10);
    check("cap_op_b", o_op_b, 32'h20);
    check("cap_valid", {31'd0, o_valid}, 32'd1);
    check_all("cap");

    // Forwarding priority, then register 0 is never forwarded.
    set_dec(1'b1, 1'b1, 5'd5, 5'd4, 5'd8, 32'h1234, 32'h20, 32'h0, 4'd2, 1'b0, 1'b0);
    tick();
    set_fwd(1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB);
    #1;
`ifdef FORWARDING_EN
    exp_a = 32'hAAAA;
`else
    exp_a = 32'h1234;
`endif
    check("fwd_exmem", o_op_a, exp_a);
    i_exmem_wr = 1'b0;
    #1;
`ifdef FORWARDING_EN
    exp_a = 32'hBBBB;
`endif
    check("fwd_memwb", o_op_a, exp_a);
    check_all("fwd");
    set_dec(1'b1, 1'b1, 5'd0, 5'd0, 5'd8, 32'h5555, 32'h6666, 32'h0, 4'd2, 1'b0, 1'b0);
    set_fwd(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB);
    tick();
    check("fwd_r0_a", o_op_a, 32'h5555);
    check("fwd_r0_store", o_store_data, 32'h6666);

    // Shift immediate: A from imm, B still from forwarded rt.
    set_dec(1'b1, 1'b1, 5'd2, 5'd6, 5'd7, 32'h4444, 32'h77, 32'hC0, 4'd5, 1'b1, 1'b0);
    tick();
    set_fwd(1'b0, 5'd0, '0, 1'b1, 5'd6, 32'h99);
    #1;
    check("shamt_op_a", o_op_a, 32'hC0);
    check_all("shamt");

    // Stall two cycles with new inputs pending, then flush during stall.
    i_stall = 1'b1;
    set_dec(1'b1, 1'b0, 5'd1, 5'd1, 5'd1, 32'h1, 32'h1, 32'h1, 4'd9, 1'b0, 1'b1);
    tick();
    check("stall1_op_a", o_op_a, 32'hC0);
    check("stall1_ctrl", {28'd0, o_alu_ctrl}, 32'd5);
    tick();
    check("stall2_rd", {27'd0, o_rd_addr}, 32'd7);
    check_all("stall");
    i_flush = 1'b1;
    tick();
    check("flush_valid", {31'd0, o_valid}, 32'd0);
    check("flush_rw", {31'd0, o_reg_write}, 32'd0);
    check("flush_ctrl", {28'd0, o_alu_ctrl}, 32'd2);
    check_all("flush");
    i_flush = 1'b0;

    // Reset during a stall discards the held instruction.
    set_dec(1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 32'h33, 32'h33, 32'h0, 4'd3, 1'b0, 1'b0);
    i_stall = 1'b0;
    tick();
    i_stall = 1'b1;
    i_rst_n = 1'b0;
    #1;
    model_clear(4'd0);
    check_all("rst_stall");
    i_rst_n = 1'b1;
    tick();
    check("rst_stall_valid", {31'd0, o_valid}, 32'd0);
    i_stall = 1'b0;

    // Randomized traffic with occasional stall/flush/reset.
    for (int unsigned k = 0; k < 400; k++) begin
      randomize_dec();
      i_stall = ($urandom_range(0, 3) == 0);
      i_flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) begin
        i_rst_n = 1'b0;
        #1;
        model_clear(4'd0);
        check_all("rand_rst");
        i_rst_n = 1'b1;
      end
      tick();
      randomize_fwd();
      #1;
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
